// File: rtl/row_window_3x3.sv
// 3x3 neighbourhood window builder for a raster pixel stream.
// Two circular line memories hold rows row-1 and row-2. Each accepted pixel shifts one column into a 3x3 register window.
module row_window_3x3 #(
   parameter int ROW_SIZE   = 1280,
   parameter int PIXEL_SIZE = 12,
   parameter int ROW_CNT_W  = 11
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [PIXEL_SIZE-1:0]         pix_in,
   input  logic                          pix_valid,
   input  logic                          sof,
   output logic [9*PIXEL_SIZE-1:0]       win,
   output logic                          win_valid,
   output logic [$clog2(ROW_SIZE)-1:0]   win_x,
   output logic [ROW_CNT_W-1:0]          win_y
);

   localparam int                   COL_W    = $clog2(ROW_SIZE);
   localparam int                   WIN_W    = 9 * PIXEL_SIZE;
   localparam logic [COL_W-1:0]     COL_LAST = COL_W'(ROW_SIZE - 1);
   localparam logic [ROW_CNT_W-1:0] ROW_MAX  = '1;

   logic [COL_W-1:0]      col_q, col_d;
   logic [ROW_CNT_W-1:0]  row_q, row_d;
   logic [WIN_W-1:0]      sr_q, sr_d;
   logic [WIN_W-1:0]      win_q, win_d;
   logic                  win_valid_q, win_valid_d;
   logic [COL_W-1:0]      win_x_q, win_x_d;
   logic [ROW_CNT_W-1:0]  win_y_q, win_y_d;

   logic [PIXEL_SIZE-1:0] lm1_mem [ROW_SIZE];
   logic [PIXEL_SIZE-1:0] lm2_mem [ROW_SIZE];
   logic [PIXEL_SIZE-1:0] lm1_rd;
   logic [PIXEL_SIZE-1:0] lm2_rd;

   logic                  accept;
   logic                  emit;
   logic [COL_W-1:0]      pos_col;
   logic [ROW_CNT_W-1:0]  pos_row;

   // sof re-anchors the accepted pixel itself at (0,0), even mid-row.
   always_comb begin
      accept  = pix_valid;
      pos_col = col_q;
      pos_row = row_q;
      if (sof) begin
         pos_col = '0;
         pos_row = '0;
      end
      emit = accept && (pos_col >= COL_W'(2)) && (pos_row >= ROW_CNT_W'(2));
   end

   // The memories are read asynchronously so the new window column lands on the accepting edge.
   assign lm1_rd = lm1_mem[pos_col];
   assign lm2_rd = lm2_mem[pos_col];

   always_comb begin
      col_d = col_q;
      row_d = row_q;
      if (accept) begin
         if (pos_col == COL_LAST) begin
            col_d = '0;
            row_d = (pos_row == ROW_MAX) ? pos_row : pos_row + ROW_CNT_W'(1);
         end else begin
            col_d = pos_col + COL_W'(1);
            row_d = pos_row;
         end
      end
   end

   always_comb begin
      sr_d = sr_q;
      if (accept) begin
         for (int r = 0; r < 3; r++) begin
            sr_d[(3*r)*PIXEL_SIZE   +: PIXEL_SIZE] = sr_q[(3*r+1)*PIXEL_SIZE +: PIXEL_SIZE];
            sr_d[(3*r+1)*PIXEL_SIZE +: PIXEL_SIZE] = sr_q[(3*r+2)*PIXEL_SIZE +: PIXEL_SIZE];
         end
         sr_d[2*PIXEL_SIZE +: PIXEL_SIZE] = lm2_rd;
         sr_d[5*PIXEL_SIZE +: PIXEL_SIZE] = lm1_rd;
         sr_d[8*PIXEL_SIZE +: PIXEL_SIZE] = pix_in;
      end
   end

   // Output registers only load on a complete interior window, so they hold otherwise.
   always_comb begin
      win_valid_d = emit;
      win_d       = win_q;
      win_x_d     = win_x_q;
      win_y_d     = win_y_q;
      if (emit) begin
         win_d   = sr_d;
         win_x_d = pos_col - COL_W'(1);
         win_y_d = pos_row - ROW_CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         col_q       <= '0;
         row_q       <= '0;
         sr_q        <= '0;
         win_q       <= '0;
         win_valid_q <= 1'b0;
         win_x_q     <= '0;
         win_y_q     <= '0;
      end else begin
         col_q       <= col_d;
         row_q       <= row_d;
         sr_q        <= sr_d;
         win_q       <= win_d;
         win_valid_q <= win_valid_d;
         win_x_q     <= win_x_d;
         win_y_q     <= win_y_d;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst && accept) begin
         lm2_mem[pos_col] <= lm1_rd;
         lm1_mem[pos_col] <= pix_in;
      end
   end

   assign win       = win_q;
   assign win_valid = win_valid_q;
   assign win_x     = win_x_q;
   assign win_y     = win_y_q;

endmodule

// File: tb/tb_row_window_3x3.sv
// Self-checking bench for row_window_3x3 (ROW_SIZE=8).
// The model keeps the current frame as an image array and cuts windows out of it directly.
module tb_row_window_3x3;

   localparam int RS = 8;
   localparam int PS = 12;
   localparam int RW = 11;
   localparam int CW = $clog2(RS);

   logic            clk = 1'b0;
   logic            rst;
   logic [PS-1:0]   pix_in;
   logic            pix_valid;
   logic            sof;
   logic [9*PS-1:0] win;
   logic            win_valid;
   logic [CW-1:0]   win_x;
   logic [RW-1:0]   win_y;

   int n_checks = 0;
   int n_fail   = 0;

   int              mcol;
   int              mrow;
   logic [PS-1:0]   img [16][RS];
   logic            exp_valid;
   logic [9*PS-1:0] exp_win;
   logic [CW-1:0]   exp_x;
   logic [RW-1:0]   exp_y;
   logic [9*PS-1:0] first_win;
   logic [9*PS+CW+RW-1:0] seq_ref [$];

   row_window_3x3 #(.ROW_SIZE(RS), .PIXEL_SIZE(PS), .ROW_CNT_W(RW)) dut (
      .clk       (clk),
      .rst       (rst),
      .pix_in    (pix_in),
      .pix_valid (pix_valid),
      .sof       (sof),
      .win       (win),
      .win_valid (win_valid),
      .win_x     (win_x),
      .win_y     (win_y)
   );

   always #5 clk = ~clk;

   function automatic logic [PS-1:0] pv(input int c, input int r);
      return PS'(r * 16 + c);
   endfunction

   task automatic model_reset();
      mcol      = 0;
      mrow      = 0;
      exp_valid = 1'b0;
      exp_win   = '0;
      exp_x     = '0;
      exp_y     = '0;
   endtask

   task automatic model_accept(input logic [PS-1:0] p, input bit s);
      if (s) begin
         mcol = 0;
         mrow = 0;
      end
      img[mrow % 16][mcol] = p;
      exp_valid = (mcol >= 2 && mrow >= 2);
      if (exp_valid) begin
         exp_x = CW'(mcol - 1);
         exp_y = RW'(mrow - 1);
         for (int k = 0; k < 9; k++)
            exp_win[k*PS +: PS] = img[(mrow - 2 + k / 3) % 16][mcol - 2 + k % 3];
      end
      mcol++;
      if (mcol == RS) begin
         mcol = 0;
         mrow++;
      end
   endtask

   task automatic cycle(input bit v, input logic [PS-1:0] p, input bit s);
      pix_valid = v;
      pix_in    = p;
      sof       = s;
      @(posedge clk);
      #1;
      pix_valid = 1'b0;
      sof       = 1'b0;
      if (v) model_accept(p, s);
      else   exp_valid = 1'b0;
   endtask

   task automatic do_reset();
      rst       = 1'b1;
      pix_valid = 1'b0;
      sof       = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      model_reset();
   endtask

   task automatic test_reset();
      rst       = 1'b1;
      pix_valid = 1'b0;
      sof       = 1'b0;
      pix_in    = '0;
      @(posedge clk);
      do_reset();
      n_checks++;
      if (win_valid !== 1'b0 || win !== '0 || win_x !== '0 || win_y !== '0) begin
         n_fail++;
         $display("FAIL reset: got v=%0b x=%0d y=%0d win=%h, expected all zero", win_valid, win_x, win_y, win);
      end
   endtask

   task automatic test_full_frame(input bit gaps);
      int pulses = 0;
      int first_c = -1;
      int first_r = -1;
      logic [CW-1:0] last_x = '0;
      logic [RW-1:0] last_y = '0;
      logic [PS-1:0] last_k8 = '0;
      string tag;
      tag = gaps ? "gapped_frame" : "full_frame";
      if (!gaps) seq_ref.delete();
      for (int r = 0; r < 5; r++) begin
         for (int c = 0; c < RS; c++) begin
            if (gaps) begin
               cycle(1'b0, PS'($urandom), 1'b0);
               n_checks++;
               if (win_valid !== exp_valid || win !== exp_win || win_x !== exp_x || win_y !== exp_y) begin
                  n_fail++;
                  $display("FAIL %s idle: got v=%0b x=%0d y=%0d win=%h, expected v=%0b x=%0d y=%0d win=%h",
                           tag, win_valid, win_x, win_y, win, exp_valid, exp_x, exp_y, exp_win);
               end
            end
            cycle(1'b1, pv(c, r), (r == 0 && c == 0));
            n_checks++;
            if (win_valid !== exp_valid || win !== exp_win || win_x !== exp_x || win_y !== exp_y) begin
               n_fail++;
               $display("FAIL %s model: got v=%0b x=%0d y=%0d win=%h, expected v=%0b x=%0d y=%0d win=%h",
                        tag, win_valid, win_x, win_y, win, exp_valid, exp_x, exp_y, exp_win);
            end
            if (win_valid === 1'b1) begin
               if (pulses == 0) begin
                  first_c = c;
                  first_r = r;
                  n_checks++;
                  if (first_c != 2 || first_r != 2 || win_x !== CW'(1) || win_y !== RW'(1) || win !== first_win) begin
                     n_fail++;
                     $display("FAIL %s first: got at (%0d,%0d) x=%0d y=%0d win=%h, expected at (2,2) x=1 y=1 win=%h",
                              tag, first_c, first_r, win_x, win_y, win, first_win);
                  end
               end
               if (!gaps) begin
                  seq_ref.push_back({win, win_x, win_y});
               end else begin
                  n_checks++;
                  if (pulses >= seq_ref.size() || {win, win_x, win_y} !== seq_ref[pulses]) begin
                     n_fail++;
                     $display("FAIL %s sequence: pulse %0d got x=%0d y=%0d win=%h, differs from gapless run",
                              tag, pulses, win_x, win_y, win);
                  end
               end
               last_x  = win_x;
               last_y  = win_y;
               last_k8 = win[8*PS +: PS];
               pulses++;
            end
         end
      end
      n_checks++;
      if (pulses != 18) begin
         n_fail++;
         $display("FAIL %s count: got %0d pulses, expected 18", tag, pulses);
      end
      n_checks++;
      if (last_x !== CW'(6) || last_y !== RW'(3) || last_k8 !== 12'h047) begin
         n_fail++;
         $display("FAIL %s last: got x=%0d y=%0d k8=%h, expected x=6 y=3 k8=047", tag, last_x, last_y, last_k8);
      end
   endtask

   task automatic test_row_wrap();
      for (int r = 0; r < 4; r++) begin
         for (int c = 0; c < RS; c++) begin
            cycle(1'b1, pv(c, r), (r == 0 && c == 0));
            n_checks++;
            if (win_valid !== exp_valid || win !== exp_win || win_x !== exp_x || win_y !== exp_y) begin
               n_fail++;
               $display("FAIL row_wrap model: got v=%0b x=%0d y=%0d win=%h, expected v=%0b x=%0d y=%0d win=%h",
                        win_valid, win_x, win_y, win, exp_valid, exp_x, exp_y, exp_win);
            end
            if (r == 2 && c == 7) begin
               n_checks++;
               if (win_valid !== 1'b1 || win_x !== CW'(6) || win_y !== RW'(1)) begin
                  n_fail++;
                  $display("FAIL row_wrap end_of_row: got v=%0b x=%0d y=%0d, expected v=1 x=6 y=1", win_valid, win_x, win_y);
               end
            end
            if (r == 3 && c < 2) begin
               n_checks++;
               if (win_valid !== 1'b0) begin
                  n_fail++;
                  $display("FAIL row_wrap span: got v=%0b after (%0d,3), expected v=0", win_valid, c);
               end
            end
            if (r == 3 && c == 2) begin
               n_checks++;
               if (win_valid !== 1'b1 || win_x !== CW'(1) || win_y !== RW'(2) || win[PS-1:0] !== 12'h010) begin
                  n_fail++;
                  $display("FAIL row_wrap resume: got v=%0b x=%0d y=%0d k0=%h, expected v=1 x=1 y=2 k0=010",
                           win_valid, win_x, win_y, win[PS-1:0]);
               end
            end
         end
      end
   endtask

   task automatic test_sof_mid();
      for (int i = 0; i < 3 * RS + 4; i++) begin
         cycle(1'b1, PS'($urandom), (i == 0));
         n_checks++;
         if (win_valid !== exp_valid || win !== exp_win || win_x !== exp_x || win_y !== exp_y) begin
            n_fail++;
            $display("FAIL sof_mid old_frame: got v=%0b x=%0d y=%0d win=%h, expected v=%0b x=%0d y=%0d win=%h",
                     win_valid, win_x, win_y, win, exp_valid, exp_x, exp_y, exp_win);
         end
      end
      for (int r = 0; r < 5; r++) begin
         for (int c = 0; c < RS; c++) begin
            cycle(1'b1, pv(c, r), (r == 0 && c == 0));
            n_checks++;
            if (win_valid !== exp_valid || win !== exp_win || win_x !== exp_x || win_y !== exp_y) begin
               n_fail++;
               $display("FAIL sof_mid model: got v=%0b x=%0d y=%0d win=%h, expected v=%0b x=%0d y=%0d win=%h",
                        win_valid, win_x, win_y, win, exp_valid, exp_x, exp_y, exp_win);
            end
            if (r < 2 || (r == 2 && c < 2)) begin
               n_checks++;
               if (win_valid !== 1'b0) begin
                  n_fail++;
                  $display("FAIL sof_mid early: got v=%0b at new (%0d,%0d), expected v=0", win_valid, c, r);
               end
            end
            if (r == 2 && c == 2) begin
               n_checks++;
               if (win_valid !== 1'b1 || win !== first_win) begin
                  n_fail++;
                  $display("FAIL sof_mid first: got v=%0b win=%h, expected v=1 win=%h", win_valid, win, first_win);
               end
            end
         end
      end
   endtask

   task automatic test_reset_mid();
      int pulses = 0;
      for (int i = 0; i < 3 * RS + 4; i++) begin
         cycle(1'b1, PS'($urandom), (i == 0));
      end
      do_reset();
      n_checks++;
      if (win_valid !== 1'b0 || win !== '0 || win_x !== '0 || win_y !== '0) begin
         n_fail++;
         $display("FAIL reset_mid clear: got v=%0b x=%0d y=%0d win=%h, expected all zero", win_valid, win_x, win_y, win);
      end
      for (int r = 0; r < 5; r++) begin
         for (int c = 0; c < RS; c++) begin
            cycle(1'b1, pv(c, r), 1'b0);
            n_checks++;
            if (win_valid !== exp_valid || win !== exp_win || win_x !== exp_x || win_y !== exp_y) begin
               n_fail++;
               $display("FAIL reset_mid model: got v=%0b x=%0d y=%0d win=%h, expected v=%0b x=%0d y=%0d win=%h",
                        win_valid, win_x, win_y, win, exp_valid, exp_x, exp_y, exp_win);
            end
            if (r == 2 && c == 2) begin
               n_checks++;
               if (win_valid !== 1'b1 || win !== first_win) begin
                  n_fail++;
                  $display("FAIL reset_mid first: got v=%0b win=%h, expected v=1 win=%h", win_valid, win, first_win);
               end
            end
            if (win_valid === 1'b1) pulses++;
         end
      end
      n_checks++;
      if (pulses != 18) begin
         n_fail++;
         $display("FAIL reset_mid count: got %0d pulses, expected 18", pulses);
      end
   endtask

   task automatic test_coords();
      int pulses = 0;
      for (int r = 0; r < 6; r++) begin
         for (int c = 0; c < RS; c++) begin
            if ($urandom_range(0, 2) == 0) begin
               cycle(1'b0, PS'($urandom), 1'($urandom));
               n_checks++;
               if (win_valid !== exp_valid || win !== exp_win || win_x !== exp_x || win_y !== exp_y) begin
                  n_fail++;
                  $display("FAIL coords idle: got v=%0b x=%0d y=%0d win=%h, expected v=%0b x=%0d y=%0d win=%h",
                           win_valid, win_x, win_y, win, exp_valid, exp_x, exp_y, exp_win);
               end
            end
            cycle(1'b1, PS'($urandom), (r == 0 && c == 0));
            n_checks++;
            if (win_valid !== exp_valid || win !== exp_win || win_x !== exp_x || win_y !== exp_y) begin
               n_fail++;
               $display("FAIL coords model: got v=%0b x=%0d y=%0d win=%h, expected v=%0b x=%0d y=%0d win=%h",
                        win_valid, win_x, win_y, win, exp_valid, exp_x, exp_y, exp_win);
            end
            if (win_valid === 1'b1) begin
               n_checks++;
               if (win_x !== CW'(pulses % 6 + 1) || win_y !== RW'(pulses / 6 + 1)) begin
                  n_fail++;
                  $display("FAIL coords position: pulse %0d got x=%0d y=%0d, expected x=%0d y=%0d",
                           pulses, win_x, win_y, pulses % 6 + 1, pulses / 6 + 1);
               end
               pulses++;
            end
         end
      end
      n_checks++;
      if (pulses != 24) begin
         n_fail++;
         $display("FAIL coords count: got %0d pulses, expected 24", pulses);
      end
   endtask

   task automatic test_random();
      int height;
      bit s;
      for (int it = 0; it < 6; it++) begin
         height = $urandom_range(3, 7);
         for (int i = 0; i < height * RS; i++) begin
            if ($urandom_range(0, 3) == 0) begin
               cycle(1'b0, PS'($urandom), 1'($urandom));
               n_checks++;
               if (win_valid !== exp_valid || win !== exp_win || win_x !== exp_x || win_y !== exp_y) begin
                  n_fail++;
                  $display("FAIL random idle: got v=%0b x=%0d y=%0d win=%h, expected v=%0b x=%0d y=%0d win=%h",
                           win_valid, win_x, win_y, win, exp_valid, exp_x, exp_y, exp_win);
               end
            end
            if ($urandom_range(0, 150) == 0) begin
               do_reset();
               n_checks++;
               if (win_valid !== exp_valid || win !== exp_win || win_x !== exp_x || win_y !== exp_y) begin
                  n_fail++;
                  $display("FAIL random reset: got v=%0b x=%0d y=%0d win=%h, expected all zero",
                           win_valid, win_x, win_y, win);
               end
            end
            s = (i == 0) || ($urandom_range(0, 60) == 0);
            cycle(1'b1, PS'($urandom), s);
            n_checks++;
            if (win_valid !== exp_valid || win !== exp_win || win_x !== exp_x || win_y !== exp_y) begin
               n_fail++;
               $display("FAIL random model: got v=%0b x=%0d y=%0d win=%h, expected v=%0b x=%0d y=%0d win=%h",
                        win_valid, win_x, win_y, win, exp_valid, exp_x, exp_y, exp_win);
            end
         end
      end
   endtask

   initial begin
      int fw [9];
      fw = '{12'h000, 12'h001, 12'h002, 12'h010, 12'h011, 12'h012, 12'h020, 12'h021, 12'h022};
      for (int k = 0; k < 9; k++) first_win[k*PS +: PS] = PS'(fw[k]);
      model_reset();

      test_reset();
      test_full_frame(1'b0);
      test_full_frame(1'b1);
      test_row_wrap();
      test_sof_mid();
      test_reset_mid();
      test_coords();
      test_random();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/row_window_3x3.md
Name: row_window_3x3

Overview:
Consumes the raster pixel stream that the row buffers carry and assembles a 3x3 neighbourhood window for kernel stages such as Sobel and Gaussian. It keeps two rows of history in internal circular line memories. It emits one window per accepted pixel once a full interior neighbourhood exists. It sits between the sensor/row-buffer stream and the convolution datapath.

Parameters:
ROW_SIZE, 1280, pixels per row (frame width).
PIXEL_SIZE, 12, bits per pixel.
ROW_CNT_W, 11, width of row counter and win_y.

Ports:
clk  input  1  clock, all logic on rising edge.
rst  input  1  synchronous, active-high reset.
pix_in  input  PIXEL_SIZE  incoming pixel, raster order.
pix_valid  input  1  pix_in accepted on this edge when high.
sof  input  1  start of frame; qualified by pix_valid; marks pixel (0,0).
win  output  9*PIXEL_SIZE  window; element k at [k*PIXEL_SIZE +: PIXEL_SIZE].
win_valid  output  1  win/win_x/win_y valid this cycle.
win_x  output  $clog2(ROW_SIZE)  column of window centre.
win_y  output  ROW_CNT_W  row of window centre.

Behaviour:
- Reset: win=0, win_valid=0, win_x=0, win_y=0, col=0, row=0. Line memories are not reset; their contents are ignored until refilled.
- Accept: pix_valid=1 on a rising edge. With pix_valid=0, no counter, memory or window register changes, and win_valid=0 on the next cycle.
- Position: an accepted pixel has position (col,row).
  - If sof=1 with pix_valid, the position is forced to (0,0) and the counters restart from there. This applies even mid-row.
  - Otherwise, col advances. At col=ROW_SIZE-1, col wraps to 0 and row increments.
  - row saturates at 2^ROW_CNT_W-1.
- Line memories: two memories, LM1 (row-1) and LM2 (row-2), each ROW_SIZE x PIXEL_SIZE, addressed by col.
  - On accept: read LM1[col] and LM2[col]; write LM2[col] <= old LM1[col]; write LM1[col] <= pix_in.
  - The write uses read-before-write semantics.
- Window shift register: 3x3 registers.
  - On accept: shift one column left.
  - The new right column is {LM2[col], LM1[col], pix_in}, top to bottom.
- Element order: k = 3*r + c, with r = 0 top (row-2) and c = 0 left (col-2).
  - Centre (k=4) is pixel (col-1, row-1).
- Output rules:
  - win_valid goes high exactly 1 cycle after an accept with col>=2 and row>=2. It is a registered output.
  - In that same cycle win holds the updated window, win_x = col-1 and win_y = row-1.
  - Accepts with col<2 or row<2 give win_valid=0. No windows span a row wrap.
- Output counts:
  - Windows per row = ROW_SIZE-2 for rows >=2.
  - A frame of H rows yields (ROW_SIZE-2)*(H-2) windows.
- Hold behaviour: win, win_x and win_y hold their last values while win_valid=0. There is no backpressure; the downstream stage must accept every win_valid pulse.
- sof mid-frame: counters restart. Stale line-memory data is never exposed, because rows 0..1 of the new frame emit no windows and overwrite the memories.
- Reset mid-frame: the next accepted pixel is treated as (0,0) regardless of sof. win_valid=0 in the cycle after reset.
- Back-to-back accepts sustain 1 window/cycle. Gaps in pix_valid are transparent; the output sequence is identical to the gapless case.

Test Plan:
All scenarios use ROW_SIZE=8, PIXEL_SIZE=12, pixel value = row*16+col.
- Full 8x5 frame, sof on first pixel, continuous pix_valid -> exactly 18 win_valid pulses.
  - First pulse: 1 cycle after pixel (2,2), win_x=1, win_y=1.
  - First window: win = {0x00,0x01,0x02,0x10,0x11,0x12,0x20,0x21,0x22} for k=0..8.
  - Last pulse: centre (6,3), k=8 = 0x47.
- Same frame with pix_valid deasserted every other cycle -> identical window sequence and coordinates; win_valid never high in a cycle following an idle cycle.
- Row wrap: pixels (7,2) then (0,3) -> pulse for centre (6,1), then no pulses for (0,3) and (1,3); next pulse after (2,3) with centre (1,2) and k=0 = 0x10.
- sof asserted at pixel (4,3) of frame 1, then a clean frame -> no win_valid until the new (2,2); first window equals the scenario-1 first window (stale rows never appear).
- rst asserted for 1 cycle mid-row 3, then a new frame without sof -> all outputs 0 in the cycle after rst; behaviour afterwards matches scenario 1.
- Coordinate check: full 8x6 frame -> 24 pulses; win_y runs 1..4; win_x runs 1..6 within each row.
